rr_onehot_arbiter: RTL

- Registered round-robin arbiter. Picks one of REQ_NUM requesters and presents the winner as a one-hot grant.
- The grant drives the sel_in of the data_selector that sits directly downstream, so the selector's output and valid always reflect a stable, single winner.
- A valid/ready handshake with the consumer holds the grant until it is accepted. The priority pointer then rotates past the winner.

---
 rtl/rr_onehot_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//
// Registered round-robin arbiter. It picks one of REQ_NUM requesters and
// presents the winner as a one-hot grant. The grant feeds the sel_in of the
// downstream data selector. A valid/ready handshake holds the grant until the
// consumer accepts it. On acceptance the priority pointer moves to the index
// just past the winner.
//
// Parameters
//   REQ_NUM    number of requesters and one-hot grant width (2..32)
//   IDX_WIDTH  width of the encoded grant index (derived, do not override)
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   req_in           per-requester pending flags (level-sensitive)
//   grant_ready_in   consumer accepts the current grant this cycle
//   grant_out        registered one-hot grant, all-zero when idle
//   grant_valid_out  grant_out holds exactly one set bit
//   grant_index_out  binary index of the granted requester, 0 when idle
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int REQ_NUM   = 4,
    parameter int IDX_WIDTH = $clog2(REQ_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_NUM-1:0]   req_in,
    input  logic                 grant_ready_in,
    output logic [REQ_NUM-1:0]   grant_out,
    output logic                 grant_valid_out,
    output logic [IDX_WIDTH-1:0] grant_index_out
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_WIDTH-1:0]   ptr;
    logic [IDX_WIDTH-1:0]   ptr_d;
    logic [REQ_NUM-1:0]     grant_d;
    logic [IDX_WIDTH-1:0]   index_d;

    logic                   fire;
    logic                   arb_en;
    logic [IDX_WIDTH-1:0]   search_ptr;
    logic                   win_found;
    logic [IDX_WIDTH-1:0]   win_idx;

    // (base + off) mod REQ_NUM; one extra bit holds the sum before wrapping.
    function automatic logic [IDX_WIDTH-1:0] wrap_add(
        input logic [IDX_WIDTH-1:0] base,
        input int                   off
    );
        logic [IDX_WIDTH:0] sum;
        sum = {1'b0, base} + (IDX_WIDTH+1)'(off);
        if (sum >= (IDX_WIDTH+1)'(REQ_NUM)) begin
            sum = sum - (IDX_WIDTH+1)'(REQ_NUM);
        end
        return sum[IDX_WIDTH-1:0];
    endfunction

    assign grant_valid_out = (state_q == GRANTED);

    // The pointer update on a handshake is also used in the same cycle's
    // search. This lets the requester just served drop to the lowest priority
    // immediately, so back-to-back grants stay fair.
    always_comb begin
        fire       = grant_valid_out && grant_ready_in;
        arb_en     = !grant_valid_out || grant_ready_in;
        search_ptr = fire ? wrap_add(grant_index_out, 1) : ptr;
    end

    // Rotating priority scan: first set request at or above search_ptr,
    // wrapping from REQ_NUM-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < REQ_NUM; off++) begin
            if (!win_found && req_in[wrap_add(search_ptr, off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(search_ptr, off);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_out;
        index_d = grant_index_out;
        ptr_d   = ptr;

        if (fire) begin
            ptr_d = wrap_add(grant_index_out, 1);
        end

        // When arb_en is low, the grant is held. Request changes are ignored
        // until the consumer accepts the grant.
        if (arb_en) begin
            if (win_found) begin
                state_d = GRANTED;
                grant_d = REQ_NUM'(1) << win_idx;
                index_d = win_idx;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                index_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_out       <= '0;
            grant_index_out <= '0;
            ptr             <= '0;
        end else begin
            state_q         <= state_d;
            grant_out       <= grant_d;
            grant_index_out <= index_d;
            ptr             <= ptr_d;
        end
    end

    // Structural invariants of the registered grant.
    a_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_out));
    a_valid_matches : assert property (@(posedge clk) disable iff (rst)
        grant_valid_out == (|grant_out));
    a_index_matches : assert property (@(posedge clk) disable iff (rst)
        grant_valid_out |-> (grant_out == (REQ_NUM'(1) << grant_index_out)));

endmodule
